// File: rtl/hazard_pkg.sv
// Shared definitions for the load-use hazard scoreboard.
//   hz_state_e   : stall FSM states
//   PEND_W       : width of each per-register pending countdown
//   LOAD_LAT_MIN / LOAD_LAT_MAX : supported range of the load latency parameter
package hazard_pkg;

  localparam int unsigned PEND_W       = 2;
  localparam int unsigned LOAD_LAT_MIN = 1;
  localparam int unsigned LOAD_LAT_MAX = 3;

  typedef enum logic [0:0] {
    HZ_RUN,
    HZ_STALL
  } hz_state_e;

endpackage

// File: rtl/pend_counter.sv
// One per-register pending countdown for the hazard scoreboard.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   set        : a load targeting this register issues; reload SET_VAL
//   clr        : the load in EX targeting this register is flushed; force 0
//   cnt        : current countdown value (nonzero = result not yet forwardable)
// Priority: clr > set > decrement-toward-zero.
module pend_counter
  import hazard_pkg::*;
#(
  parameter logic [PEND_W-1:0] SET_VAL = 2'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set,
  input  logic              clr,
  output logic [PEND_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (set) begin
      cnt <= SET_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard controller. Records the destination of each load as it leaves ID,
// stalls ID while a consumer reads a register whose load result is not yet forwardable,
// and flags the bubble that the stall (or a branch flush) leaves in EX.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   id_valid                   : ID holds a real instruction
//   id_rs, id_rt               : source register addresses
//   id_use_rs, id_use_rt       : matching source is actually read
//   id_rd, id_rw               : destination register and its write enable
//   id_is_load                 : ID instruction is a load
//   ex_flush                   : taken branch in EX, squashes ID and EX
//   id_stall                   : combinational; hold PC and IF/ID
//   ex_bubble                  : registered; EX holds an inserted bubble
//   stall_busy                 : registered; FSM is in HZ_STALL
//   stall_cnt                  : saturating stall-cycle counter
// Build option: define HAZARD_PERF_EN to include the stall-cycle counter; otherwise
// stall_cnt is tied to 0.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG     = 16,
  parameter int unsigned AW       = 4,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [AW-1:0] id_rd,
  input  logic          id_rw,
  input  logic          id_is_load,
  input  logic          ex_flush,
  output logic          id_stall,
  output logic          ex_bubble,
  output logic          stall_busy,
  output logic [15:0]   stall_cnt
);

  // Out-of-range latencies are clamped into the supported window so the
  // countdown never wraps in its 2-bit field.
  localparam int unsigned LatEff = (LOAD_LAT < LOAD_LAT_MIN) ? LOAD_LAT_MIN :
                                   (LOAD_LAT > LOAD_LAT_MAX) ? LOAD_LAT_MAX : LOAD_LAT;
  localparam logic [PEND_W-1:0] LatVal = PEND_W'(LatEff);

  logic [PEND_W-1:0] pend [NREG];
  logic              issue;
  logic              ld_issue;
  logic              ex_ld_v;
  logic [AW-1:0]     ex_ld_rd;
  hz_state_e         state;

  assign id_stall = id_valid & ~ex_flush &
                    ((id_use_rs & (pend[id_rs] != '0)) |
                     (id_use_rt & (pend[id_rt] != '0)));

  assign issue    = id_valid & ~id_stall & ~ex_flush;
  assign ld_issue = issue & id_is_load & id_rw;

  for (genvar r = 0; r < NREG; r++) begin : g_pend
    pend_counter #(
      .SET_VAL(LatVal)
    ) u_pend (
      .clk(clk),
      .rst_n(rst_n),
      .set(ld_issue & (id_rd == AW'(r))),
      // Only the load sitting in EX can be squashed; older loads have left.
      .clr(ex_flush & ex_ld_v & (ex_ld_rd == AW'(r))),
      .cnt(pend[r])
    );
  end

  // Shadow of the load now in EX; empty whenever nothing issued (stall, flush, non-load).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ld_v  <= 1'b0;
      ex_ld_rd <= '0;
    end else begin
      ex_ld_v  <= ld_issue;
      ex_ld_rd <= id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HZ_RUN;
      stall_busy <= 1'b0;
      ex_bubble  <= 1'b0;
    end else begin
      case (state)
        HZ_RUN: begin
          if (id_stall) begin
            state      <= HZ_STALL;
            stall_busy <= 1'b1;
          end else begin
            stall_busy <= 1'b0;
          end
        end
        HZ_STALL: begin
          if (!id_stall) begin
            state      <= HZ_RUN;
            stall_busy <= 1'b0;
          end else begin
            stall_busy <= 1'b1;
          end
        end
        default: begin
          state      <= HZ_RUN;
          stall_busy <= 1'b0;
        end
      endcase
      // Nothing issues into EX on a stall or flush cycle.
      ex_bubble <= id_stall | ex_flush;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (id_stall && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard. Two instances share the stimulus:
// u_dut1 (LOAD_LAT=1) and u_dut3 (LOAD_LAT=3); each directed vector names the
// instance it targets. The driver pushes hand-computed expectations; the monitor
// pops one per cycle on the falling edge and compares.
module tb_hazard_scoreboard;

  typedef struct packed {
    logic       valid;
    logic [3:0] rs;
    logic [3:0] rt;
    logic       urs;
    logic       urt;
    logic [3:0] rd;
    logic       rw;
    logic       ld;
  } instr_t;

  typedef struct {
    bit          sel;
    logic        st;
    logic        bb;
    logic        bz;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic id_rw = 1'b0, id_is_load = 1'b0, ex_flush = 1'b0;
  logic [3:0] id_rs = '0, id_rt = '0, id_rd = '0;

  logic stall1, bub1, busy1, stall3, bub3, busy3;
  logic [15:0] cnt1, cnt3;

  exp_t exp_q[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  int cnt_run = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREG(16), .AW(4), .LOAD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_rw(id_rw),
    .id_is_load(id_is_load), .ex_flush(ex_flush), .id_stall(stall1),
    .ex_bubble(bub1), .stall_busy(busy1), .stall_cnt(cnt1)
  );

  hazard_scoreboard #(.NREG(16), .AW(4), .LOAD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_rw(id_rw),
    .id_is_load(id_is_load), .ex_flush(ex_flush), .id_stall(stall3),
    .ex_bubble(bub3), .stall_busy(busy3), .stall_cnt(cnt3)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.sel) begin
        chk({e.name, " id_stall"}, {15'd0, stall3}, {15'd0, e.st});
        chk({e.name, " ex_bubble"}, {15'd0, bub3}, {15'd0, e.bb});
        chk({e.name, " stall_busy"}, {15'd0, busy3}, {15'd0, e.bz});
        chk({e.name, " stall_cnt"}, cnt3, e.cnt);
      end else begin
        chk({e.name, " id_stall"}, {15'd0, stall1}, {15'd0, e.st});
        chk({e.name, " ex_bubble"}, {15'd0, bub1}, {15'd0, e.bb});
        chk({e.name, " stall_busy"}, {15'd0, busy1}, {15'd0, e.bz});
        chk({e.name, " stall_cnt"}, cnt1, e.cnt);
      end
    end
  end

  function automatic instr_t idle();
    instr_t i;
    i = '0;
    return i;
  endfunction

  function automatic instr_t ld(input logic [3:0] rd, input logic [3:0] rs, input logic urs);
    instr_t i;
    i = '0;
    i.valid = 1'b1; i.rd = rd; i.rs = rs; i.urs = urs; i.rw = 1'b1; i.ld = 1'b1;
    return i;
  endfunction

  function automatic instr_t alu(input logic [3:0] rd, input logic [3:0] rs,
                                 input logic [3:0] rt, input logic urs, input logic urt);
    instr_t i;
    i = '0;
    i.valid = 1'b1; i.rd = rd; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
    i.rw = 1'b1;
    return i;
  endfunction

  task automatic apply(input instr_t ins, input logic fl);
    id_valid = ins.valid; id_rs = ins.rs; id_rt = ins.rt; id_use_rs = ins.urs;
    id_use_rt = ins.urt; id_rd = ins.rd; id_rw = ins.rw; id_is_load = ins.ld;
    ex_flush = fl;
  endtask

  task automatic push(input bit sel, input logic es, input logic eb, input logic ebz,
                      input string nm);
    exp_t x;
    x.sel = sel; x.st = es; x.bb = eb; x.bz = ebz; x.name = nm;
`ifdef HAZARD_PERF_EN
    x.cnt = (cnt_run > 65535) ? 16'hFFFF : 16'(cnt_run);
`else
    x.cnt = 16'h0000;
`endif
    exp_q.push_back(x);
    if (es) cnt_run++;
  endtask

  // One ID cycle: drive after the rising edge, queue the expected outputs.
  task automatic cyc(input bit sel, input instr_t ins, input logic fl, input logic es,
                     input logic eb, input logic ebz, input string nm);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(ins, fl);
    push(sel, es, eb, ebz, nm);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    apply(idle(), 1'b0);
    cnt_run = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    apply(idle(), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state, then load r5 / add reading r5 via rs, LOAD_LAT=1.
    cyc(0, idle(),                    0, 0, 0, 0, "rst_idle");
    cyc(0, ld(5, 0, 0),               0, 0, 0, 0, "l1_load");
    cyc(0, alu(6, 5, 2, 1, 1),        0, 1, 0, 0, "l1_stall");
    cyc(0, alu(6, 5, 2, 1, 1),        0, 0, 1, 1, "l1_issue");
    cyc(0, idle(),                    0, 0, 0, 0, "l1_after");

    // LOAD_LAT=3, consumer reads r5 via rt: three stall cycles.
    do_reset();
    cyc(1, ld(5, 0, 0),               0, 0, 0, 0, "l3_load");
    cyc(1, alu(8, 1, 5, 1, 1),        0, 1, 0, 0, "l3_stall0");
    cyc(1, alu(8, 1, 5, 1, 1),        0, 1, 1, 1, "l3_stall1");
    cyc(1, alu(8, 1, 5, 1, 1),        0, 1, 1, 1, "l3_stall2");
    cyc(1, alu(8, 1, 5, 1, 1),        0, 0, 1, 1, "l3_issue");
    cyc(1, idle(),                    0, 0, 0, 0, "l3_after");

    // Flush while load r3 is in EX; the squashed ID load of r4 must not be recorded.
    do_reset();
    cyc(1, ld(3, 0, 0),               0, 0, 0, 0, "fl_load");
    cyc(1, ld(4, 3, 1),               1, 0, 0, 0, "fl_flush");
    cyc(1, alu(9, 3, 4, 1, 1),        0, 0, 1, 0, "fl_consumer");
    cyc(1, idle(),                    0, 0, 0, 0, "fl_after");

    // Back-to-back loads to r7 (second has rs=7 unused), consumer times from the second.
    do_reset();
    cyc(1, ld(7, 0, 0),               0, 0, 0, 0, "bb_load0");
    cyc(1, ld(7, 7, 0),               0, 0, 0, 0, "bb_load1");
    cyc(1, alu(10, 7, 0, 1, 0),       0, 1, 0, 0, "bb_stall0");
    cyc(1, alu(10, 7, 0, 1, 0),       0, 1, 1, 1, "bb_stall1");
    cyc(1, alu(10, 7, 0, 1, 0),       0, 1, 1, 1, "bb_stall2");
    cyc(1, alu(10, 7, 0, 1, 0),       0, 0, 1, 1, "bb_issue");
    cyc(1, ld(7, 0, 0),               0, 0, 0, 0, "bb_load2");
    cyc(1, alu(11, 7, 7, 0, 0),       0, 0, 0, 0, "bb_unused_src");

    // Two blocking sources: stall length follows the larger remaining count.
    do_reset();
    cyc(1, ld(1, 0, 0),               0, 0, 0, 0, "two_load1");
    cyc(1, ld(2, 1, 0),               0, 0, 0, 0, "two_load2");
    cyc(1, alu(12, 1, 2, 1, 1),       0, 1, 0, 0, "two_stall0");
    cyc(1, alu(12, 1, 2, 1, 1),       0, 1, 1, 1, "two_stall1");
    cyc(1, alu(12, 1, 2, 1, 1),       0, 1, 1, 1, "two_stall2");
    cyc(1, alu(12, 1, 2, 1, 1),       0, 0, 1, 1, "two_issue");

    // Asynchronous reset in the middle of a stall.
    do_reset();
    cyc(1, ld(5, 0, 0),               0, 0, 0, 0, "mr_load");
    cyc(1, alu(6, 5, 0, 1, 0),        0, 1, 0, 0, "mr_stall0");
    cyc(1, alu(6, 5, 0, 1, 0),        0, 1, 1, 1, "mr_stall1");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    cnt_run = 0;
    push(1, 0, 0, 0, "mr_in_reset");
    cyc(1, idle(),                    0, 0, 0, 0, "mr_release");
    cyc(1, alu(6, 5, 0, 1, 0),        0, 0, 0, 0, "mr_consumer");

`ifdef HAZARD_PERF_EN
    // A self-dependent load held in ID stalls 3 of every 4 cycles: drive the
    // counter past 16'hFFFF and check it saturates.
    do_reset();
    for (int i = 0; i < 87400; i++) begin
      cyc(1, ld(1, 1, 1), 0, (i % 4) != 0, (i > 0) && ((i % 4) != 1),
          (i > 0) && ((i % 4) != 1), "perf");
    end
`endif

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
